// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: synchronizes and filters a ripple counter bus, flags wraps, hands out clean captures
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   cnt_in     : raw ripple counter bits, asynchronous to clk
//   sample_req : capture request, honoured only while idle
//   out_ready  : consumer accepts the held capture
//   out_valid  : capture held and available
//   out_count  : captured count
//   out_wrap   : a wrap occurred since the previous accepted capture
//   out_err    : capture was forced by timeout, value not filtered
//   wrap_pulse : one-cycle pulse per detected wrap
//   busy       : settling or holding a capture
module ripple_count_sampler #(
   parameter int WIDTH = 4,
   parameter int STABLE_CYCLES = 2,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             sample_req,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_count,
   output logic             out_wrap,
   output logic             out_err,
   output logic             wrap_pulse,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
   localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   state_t r_state;
   logic [WIDTH-1:0] r_s1, r_sync, r_prev, r_stable_val;
   logic [3:0] r_run;
   logic [7:0] r_timer;
   logic r_wrap_pending;
   logic [3:0] w_run;
   logic w_stable, w_update, w_wrap, w_capture;
   // the run count includes this cycle's comparison, so a sample that differs
   // from its predecessor is never trusted, even if the previous run was saturated
   always_comb begin
      w_run = (r_sync != r_prev) ? 4'd0 : (r_run == RUN_MAX) ? r_run : r_run + 4'd1;
      w_stable = (w_run == RUN_MAX);
      w_update = w_stable && (r_sync != r_stable_val);
      w_wrap = w_update && (r_sync < r_stable_val);
      w_capture = (r_state == SETTLE) && (w_stable || r_timer == TMO_LAST);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_s1 <= '0;
         r_sync <= '0;
         r_prev <= '0;
         r_run <= '0;
         r_stable_val <= '0;
         r_wrap_pending <= 1'b0;
         r_timer <= '0;
         out_valid <= 1'b0;
         out_count <= '0;
         out_wrap <= 1'b0;
         out_err <= 1'b0;
         wrap_pulse <= 1'b0;
         busy <= 1'b0;
      end else begin
         r_s1 <= cnt_in;
         r_sync <= r_s1;
         r_prev <= r_sync;
         r_run <= w_run;
         if (w_update) r_stable_val <= r_sync;
         wrap_pulse <= w_wrap;
         // a wrap seen on the capture edge goes straight into out_wrap instead of pending
         r_wrap_pending <= !w_capture && (r_wrap_pending || w_wrap);
         case (r_state)
            IDLE: if (sample_req) begin
               r_state <= SETTLE;
               r_timer <= '0;
               busy <= 1'b1;
            end
            SETTLE: begin
               r_timer <= r_timer + 8'd1;
               if (w_capture) begin
                  r_state <= HOLD;
                  out_valid <= 1'b1;
                  out_count <= r_sync;
                  out_err <= !w_stable;
                  out_wrap <= r_wrap_pending || w_wrap;
               end
            end
            HOLD: if (out_ready) begin
               r_state <= IDLE;
               out_valid <= 1'b0;
               out_wrap <= 1'b0;
               out_err <= 1'b0;
               busy <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb_ripple_count_sampler: self-checking bench for ripple_count_sampler
module tb_ripple_count_sampler;
   localparam int W = 4;
   localparam int S = 2;
   localparam int T = 64;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sample_req = 1'b0;
   logic out_ready = 1'b0;
   logic [W-1:0] cnt_in = '0;
   logic out_valid, out_wrap, out_err, wrap_pulse, busy;
   logic [W-1:0] out_count;
   int errors = 0;
   int checks = 0;
   int pulses = 0;

   ripple_count_sampler #(.WIDTH(W), .STABLE_CYCLES(S), .TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .cnt_in(cnt_in), .sample_req(sample_req), .out_ready(out_ready),
      .out_valid(out_valid), .out_count(out_count), .out_wrap(out_wrap), .out_err(out_err),
      .wrap_pulse(wrap_pulse), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference: trusted value = last S+1 synchronized samples identical
   int hist[$];
   int m_s1, m_sv, m_mode, m_timer;
   bit m_valid, m_wrap, m_err, m_pulse, m_busy, m_pend;
   logic [W-1:0] m_count;

   function automatic bit m_stable();
      if (hist.size() < S + 1) return 1'b0;
      for (int i = 1; i <= S; i++)
         if (hist[hist.size() - 1 - i] != hist[hist.size() - 1]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step();
      bit st, upd, wrp, cap;
      int cur;
      if (reset) begin
         m_s1 = 0; m_sv = 0; m_mode = 0; m_timer = 0; hist = {0, 0};
         m_valid = 0; m_wrap = 0; m_err = 0; m_pulse = 0; m_busy = 0; m_pend = 0; m_count = '0;
         return;
      end
      st = m_stable();
      cur = hist[hist.size() - 1];
      upd = st && cur != m_sv;
      wrp = upd && cur < m_sv;
      cap = (m_mode == 1) && (st || m_timer == T - 1);
      if (m_mode == 0) begin
         if (sample_req) begin m_mode = 1; m_timer = 0; m_busy = 1; end
      end else if (m_mode == 1) begin
         m_timer++;
         if (cap) begin
            m_mode = 2; m_valid = 1; m_count = cur[W-1:0]; m_err = !st; m_wrap = m_pend || wrp;
         end
      end else if (out_ready) begin
         m_mode = 0; m_valid = 0; m_wrap = 0; m_err = 0; m_busy = 0;
      end
      m_pulse = wrp;
      m_pend = !cap && (m_pend || wrp);
      if (upd) m_sv = cur;
      hist.push_back(m_s1);
      m_s1 = int'(cnt_in);
      if (hist.size() > 16) void'(hist.pop_front());
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("model", {out_valid, out_count, out_wrap, out_err, wrap_pulse, busy},
            {m_valid, m_count, m_wrap, m_err, m_pulse, m_busy});
      if (wrap_pulse === 1'b1) pulses++;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic capture(string name, logic [W-1:0] c, logic w, logic e);
      int n;
      n = 0;
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      while (out_valid !== 1'b1 && n < 200) begin tick(); n++; end
      check({name, "_valid"}, out_valid, 1);
      check({name, "_count"}, out_count, c);
      check({name, "_wrap"}, out_wrap, w);
      check({name, "_err"}, out_err, e);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_done"}, {out_valid, busy}, 0);
   endtask

   typedef struct {
      logic rst;
      logic [W-1:0] cnt;
      logic req;
      logic rdy;
      logic [8:0] exp;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(logic rst, logic [W-1:0] c, logic rq, logic rd,
                               logic v, logic [W-1:0] oc, logic b);
      vec_t r;
      r.rst = rst; r.cnt = c; r.req = rq; r.rdy = rd;
      r.exp = {v, oc, 1'b0, 1'b0, 1'b0, b};
      tbl.push_back(r);
   endfunction

   initial begin
      int first, seen, hold;
      add(1, 9, 0, 0, 0, 0, 0);
      add(1, 9, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) add(0, 9, 0, 0, 0, 0, 0);
      add(0, 9, 1, 0, 0, 0, 1);
      add(0, 9, 0, 0, 1, 9, 1);
      for (int i = 0; i < 10; i++) add(0, 9, 0, 0, 1, 9, 1);
      add(0, 9, 0, 1, 0, 9, 0);
      add(0, 9, 0, 0, 0, 9, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst; cnt_in = tbl[i].cnt; sample_req = tbl[i].req; out_ready = tbl[i].rdy;
         tick();
         check($sformatf("vec%0d", i), {out_valid, out_count, out_wrap, out_err, wrap_pulse, busy}, tbl[i].exp);
      end
      sample_req = 1'b0; out_ready = 1'b0;

      pulses = 0;
      cnt_in = 14; run(8);
      cnt_in = 15; run(8);
      cnt_in = 0; first = -1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (wrap_pulse === 1'b1 && first < 0) first = i;
      end
      check("wrap_pulse_count", pulses, 1);
      check("wrap_pulse_delay_in_3_to_6", (first >= 3 && first <= 6), 1);
      capture("wrap_cap", 0, 1, 0);
      capture("wrap_cap2", 0, 0, 0);

      pulses = 0;
      cnt_in = 7; run(10);
      cnt_in = 6; tick();
      cnt_in = 4; tick();
      cnt_in = 8; run(10);
      check("glitch_no_wrap", pulses, 0);
      capture("glitch_cap", 8, 0, 0);

      for (int i = 0; i < 4; i++) begin cnt_in = (i % 2 == 1) ? 4'd12 : 4'd9; tick(); end
      cnt_in = (cnt_in == 4'd9) ? 4'd12 : 4'd9;
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      seen = 0;
      while (out_valid !== 1'b1 && seen < 100) begin
         cnt_in = (cnt_in == 4'd9) ? 4'd12 : 4'd9;
         tick();
         seen++;
      end
      check("timeout_cycles", seen, T);
      check("timeout_err", out_err, 1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("timeout_done", {out_valid, out_err, busy}, 0);

      cnt_in = 13; run(8);
      sample_req = 1'b1; tick(); sample_req = 1'b0; tick();
      check("hold_valid", {out_valid, out_count}, {1'b1, 4'd13});
      sample_req = 1'b1; tick(); sample_req = 1'b0;
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (out_valid !== 1'b0 || busy !== 1'b0) seen++; end
      check("ignored_req", seen, 0);

      cnt_in = 3; run(8);
      for (int i = 0; i < 3; i++) begin cnt_in = (i % 2 == 1) ? 4'd1 : 4'd6; tick(); end
      sample_req = 1'b1; cnt_in = 4'd1; tick(); sample_req = 1'b0;
      for (int i = 0; i < 4; i++) begin cnt_in = (cnt_in == 4'd1) ? 4'd6 : 4'd1; tick(); end
      check("settle_busy", {out_valid, busy}, {1'b0, 1'b1});
      reset = 1'b1; tick(); reset = 1'b0;
      check("reset_in_settle", {out_valid, busy, out_wrap, out_err}, 0);
      cnt_in = 10; run(8);
      capture("post_reset_cap", 10, 0, 0);

      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            cnt_in = W'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(1, 4));
         end
         hold--;
         sample_req = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 2) == 0);
         reset = ($urandom_range(0, 399) == 0);
         tick();
      end
      reset = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
